// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between the cpu and a DMA/IO
// requester. The winning request is latched, presented to memory for
// MEM_WAIT+1 cycles, and completed with a one-cycle ack plus read data.
// Build option: define ARB_CPU_PRIORITY_EN for fixed cpu priority on a tie;
// otherwise ties are resolved round-robin against the last owner.
module mem_bus_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MEM_WAIT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_rw,
  input  logic [AW-1:0] cpu_address,
  input  logic [DW-1:0] cpu_datao,
  output logic [DW-1:0] cpu_data,
  output logic          cpu_ack,
  input  logic          dma_req,
  input  logic          dma_rw,
  input  logic [AW-1:0] dma_address,
  input  logic [DW-1:0] dma_datao,
  output logic [DW-1:0] dma_data,
  output logic          dma_ack,
  output logic          mem_en,
  output logic          mem_rw,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_datao,
  input  logic [DW-1:0] mem_data,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT);

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    wait_cnt;
  logic          lat_rw;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_data;
  logic [DW-1:0] rdata;
  logic          last_owner;
  logic          owner_q;
  logic          any_req;
  logic          grant_dma;

  // Arbitration: decide which requester wins when the port is idle
  always_comb begin
    any_req = cpu_req | dma_req;
`ifdef ARB_CPU_PRIORITY_EN
    grant_dma = dma_req & ~cpu_req;
`else
    // On a tie, the requester that did not own the port last time wins
    grant_dma = dma_req & (~cpu_req | ~last_owner);
`endif
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: IDLE -> ACCESS for MEM_WAIT+1 cycles -> DONE -> IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (wait_cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the current state and the latched request
  always_comb begin
    mem_en  = (state == ACCESS);
    mem_rw  = (state == ACCESS) & lat_rw;
    busy    = (state != IDLE);
    cpu_ack = (state == DONE) & ~owner_q;
    dma_ack = (state == DONE) &  owner_q;
  end

  // Request latch, wait counter, read-data capture and ownership tracking
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt   <= 4'd0;
      lat_rw     <= 1'b0;
      lat_addr   <= '0;
      lat_data   <= '0;
      rdata      <= '0;
      last_owner <= 1'b1;
      owner_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            wait_cnt <= WAIT_LOAD;
            owner_q  <= grant_dma;
            lat_rw   <= grant_dma ? dma_rw      : cpu_rw;
            lat_addr <= grant_dma ? dma_address : cpu_address;
            lat_data <= grant_dma ? dma_datao   : cpu_datao;
          end
        end
        ACCESS: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            // Memory read data is valid only in the final access cycle
            if (!lat_rw) rdata <= mem_data;
            last_owner <= owner_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_address = lat_addr;
  assign mem_datao   = lat_data;
  assign cpu_data    = rdata;
  assign dma_data    = rdata;
  assign owner       = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a cycle table for the directed scenarios, a few
// hand-written sequences around asynchronous reset, and a randomized run
// compared against a transaction-level model of the arbiter.
module tb_mem_bus_arbiter;

  localparam int MW = 1;
`ifdef ARB_CPU_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  a_req = 2'b00;
  logic [1:0]  a_rw  = 2'b00;
  logic [31:0] a_addr [2];
  logic [31:0] a_dat  [2];
  logic        use_hash = 1'b0;
  logic [31:0] tbl_mdat = 32'h0;

  logic [31:0] cpu_data, dma_data, mem_address, mem_datao, mem_data;
  logic        cpu_ack, dma_ack, mem_en, mem_rw, busy, owner;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  assign mem_data = use_hash ? hash(mem_address) : tbl_mdat;

  mem_bus_arbiter #(.AW(32), .DW(32), .MEM_WAIT(MW)) u_dut (
    .clock       (clock),
    .reset       (reset),
    .cpu_req     (a_req[0]),
    .cpu_rw      (a_rw[0]),
    .cpu_address (a_addr[0]),
    .cpu_datao   (a_dat[0]),
    .cpu_data    (cpu_data),
    .cpu_ack     (cpu_ack),
    .dma_req     (a_req[1]),
    .dma_rw      (a_rw[1]),
    .dma_address (a_addr[1]),
    .dma_datao   (a_dat[1]),
    .dma_data    (dma_data),
    .dma_ack     (dma_ack),
    .mem_en      (mem_en),
    .mem_rw      (mem_rw),
    .mem_address (mem_address),
    .mem_datao   (mem_datao),
    .mem_data    (mem_data),
    .busy        (busy),
    .owner       (owner)
  );

  always #5 clock = ~clock;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One row = inputs driven during a cycle and outputs expected in that cycle
  typedef struct {
    logic        creq, crw;
    logic [31:0] caddr;
    logic        dreq, drw;
    logic [31:0] daddr, ddat, mdat;
    logic        en, rw;
    logic [31:0] addr, datao;
    logic        cack, dack, bsy, own;
    logic [31:0] rd;
  } vec_t;

  localparam int NROW = 20;
  vec_t tbl [NROW];

  task automatic set_in(input int i, input logic creq, input logic crw, input logic [31:0] caddr,
                        input logic dreq, input logic drw, input logic [31:0] daddr,
                        input logic [31:0] ddat, input logic [31:0] mdat);
    tbl[i].creq = creq; tbl[i].crw = crw; tbl[i].caddr = caddr;
    tbl[i].dreq = dreq; tbl[i].drw = drw; tbl[i].daddr = daddr;
    tbl[i].ddat = ddat; tbl[i].mdat = mdat;
  endtask

  task automatic set_ex(input int i, input logic en, input logic rw, input logic [31:0] addr,
                        input logic [31:0] datao, input logic cack, input logic dack,
                        input logic bsy, input logic own, input logic [31:0] rd);
    tbl[i].en = en; tbl[i].rw = rw; tbl[i].addr = addr; tbl[i].datao = datao;
    tbl[i].cack = cack; tbl[i].dack = dack; tbl[i].bsy = bsy; tbl[i].own = own;
    tbl[i].rd = rd;
  endtask

  // Transaction-level model state for the randomized run
  bit          m_act;
  int          m_acc_s, m_ack_t;
  logic        m_win, m_last, m_own, m_rw;
  logic [31:0] m_addr, m_dat, m_rd;

  initial begin
    a_addr[0] = '0; a_addr[1] = '0; a_dat[0] = '0; a_dat[1] = '0;

    // cpu read (0x10), dma write (0x200), then both held with a dma address change
    set_in( 0, 1,0,32'h10, 0,0,32'h0,   32'h0,        32'h0);
    set_ex( 0, 0,0,32'h0,  32'h0, 0,0, 0,0, 32'h0);
    set_in( 1, 1,0,32'h10, 0,0,32'h0,   32'h0,        32'hDEADBEEF);
    set_ex( 1, 1,0,32'h10, 32'h0, 0,0, 1,0, 32'h0);
    set_in( 2, 1,0,32'h10, 0,0,32'h0,   32'h0,        32'hDEADBEEF);
    set_ex( 2, 1,0,32'h10, 32'h0, 0,0, 1,0, 32'h0);
    set_in( 3, 0,0,32'h10, 1,1,32'h200, 32'h12345678, 32'h0);
    set_ex( 3, 0,0,32'h0,  32'h0, 1,0, 1,0, 32'hDEADBEEF);
    set_in( 4, 0,0,32'h10, 1,1,32'h200, 32'h12345678, 32'h0);
    set_ex( 4, 0,0,32'h0,  32'h0, 0,0, 0,0, 32'hDEADBEEF);
    set_in( 5, 0,0,32'h10, 1,1,32'h200, 32'h12345678, 32'h0);
    set_ex( 5, 1,1,32'h200,32'h12345678, 0,0, 1,1, 32'hDEADBEEF);
    set_in( 6, 0,0,32'h10, 1,1,32'h200, 32'h12345678, 32'h0);
    set_ex( 6, 1,1,32'h200,32'h12345678, 0,0, 1,1, 32'hDEADBEEF);
    set_in( 7, 0,0,32'h10, 0,1,32'h200, 32'h12345678, 32'h0);
    set_ex( 7, 0,0,32'h0,  32'h0, 0,1, 1,1, 32'hDEADBEEF);
    set_in( 8, 1,0,32'h40, 1,0,32'h300, 32'h0,        32'h0);
    set_ex( 8, 0,0,32'h0,  32'h0, 0,0, 0,1, 32'hDEADBEEF);
    set_in( 9, 1,0,32'h40, 1,0,32'h304, 32'h0,        32'h00001111);
    set_ex( 9, 1,0,32'h40, 32'h0, 0,0, 1,0, 32'hDEADBEEF);
    set_in(10, 1,0,32'h40, 1,0,32'h304, 32'h0,        32'h00001111);
    set_ex(10, 1,0,32'h40, 32'h0, 0,0, 1,0, 32'hDEADBEEF);
    set_in(11, 1,0,32'h40, 1,0,32'h304, 32'h0,        32'h0);
    set_ex(11, 0,0,32'h0,  32'h0, 1,0, 1,0, 32'h00001111);
    for (int i = 12; i < 15; i++) set_in(i, 1,0,32'h40, 1,0,32'h304, 32'h0, 32'h22223333);
    set_in(15, 1,0,32'h40, 1,0,32'h304, 32'h0,        32'h0);
    set_ex(12, 0,0,32'h0,  32'h0, 0,0, 0,0, 32'h00001111);
    if (PRIO) begin
      set_ex(13, 1,0,32'h40,  32'h0, 0,0, 1,0, 32'h00001111);
      set_ex(14, 1,0,32'h40,  32'h0, 0,0, 1,0, 32'h00001111);
      set_ex(15, 0,0,32'h0,   32'h0, 1,0, 1,0, 32'h22223333);
      set_ex(16, 0,0,32'h0,   32'h0, 0,0, 0,0, 32'h22223333);
    end else begin
      set_ex(13, 1,0,32'h304, 32'h0, 0,0, 1,1, 32'h00001111);
      set_ex(14, 1,0,32'h304, 32'h0, 0,0, 1,1, 32'h00001111);
      set_ex(15, 0,0,32'h0,   32'h0, 0,1, 1,1, 32'h22223333);
      set_ex(16, 0,0,32'h0,   32'h0, 0,0, 0,1, 32'h22223333);
    end
    for (int i = 16; i < 19; i++) set_in(i, 1,0,32'h40, 1,0,32'h304, 32'h0, 32'h44445555);
    set_ex(17, 1,0,32'h40, 32'h0, 0,0, 1,0, 32'h22223333);
    set_ex(18, 1,0,32'h40, 32'h0, 0,0, 1,0, 32'h22223333);
    set_in(19, 0,0,32'h0,  0,0,32'h0,   32'h0,        32'h0);
    set_ex(19, 0,0,32'h0,  32'h0, 1,0, 1,0, 32'h44445555);

    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // ---------------- table-driven cycles ----------------
    for (int i = 0; i < NROW; i++) begin
      @(posedge clock); #1;
      chk1 ($sformatf("r%0d mem_en", i),   mem_en,   tbl[i].en);
      chk1 ($sformatf("r%0d busy", i),     busy,     tbl[i].bsy);
      chk1 ($sformatf("r%0d cpu_ack", i),  cpu_ack,  tbl[i].cack);
      chk1 ($sformatf("r%0d dma_ack", i),  dma_ack,  tbl[i].dack);
      chk1 ($sformatf("r%0d owner", i),    owner,    tbl[i].own);
      chk32($sformatf("r%0d cpu_data", i), cpu_data, tbl[i].rd);
      chk32($sformatf("r%0d dma_data", i), dma_data, tbl[i].rd);
      if (tbl[i].en) begin
        chk32($sformatf("r%0d mem_address", i), mem_address, tbl[i].addr);
        chk1 ($sformatf("r%0d mem_rw", i),      mem_rw,      tbl[i].rw);
        if (tbl[i].rw) chk32($sformatf("r%0d mem_datao", i), mem_datao, tbl[i].datao);
      end
      a_req     = {tbl[i].dreq, tbl[i].creq};
      a_rw      = {tbl[i].drw,  tbl[i].crw};
      a_addr[0] = tbl[i].caddr;
      a_addr[1] = tbl[i].daddr;
      a_dat[0]  = 32'h0;
      a_dat[1]  = tbl[i].ddat;
      tbl_mdat  = tbl[i].mdat;
    end

    // ---------------- reset in the middle of a dma access ----------------
    @(posedge clock); #1;
    chk1("seq idle busy", busy, 1'b0);
    a_req = 2'b10; a_rw[1] = 1'b0; a_addr[1] = 32'h500;
    @(posedge clock); #1;
    chk1("seq acc1 mem_en", mem_en, 1'b1);
    chk1("seq acc1 owner", owner, 1'b1);
    @(posedge clock); #1;
    chk1("seq acc2 mem_en", mem_en, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk1 ("seq rst mem_en", mem_en, 1'b0);
    chk1 ("seq rst busy", busy, 1'b0);
    chk1 ("seq rst mem_rw", mem_rw, 1'b0);
    chk1 ("seq rst dma_ack", dma_ack, 1'b0);
    chk1 ("seq rst cpu_ack", cpu_ack, 1'b0);
    chk1 ("seq rst owner", owner, 1'b0);
    chk32("seq rst cpu_data", cpu_data, 32'h0);
    @(negedge clock);
    chk1("seq rst held busy", busy, 1'b0);
    reset = 1'b0;
    a_req = 2'b11; a_rw = 2'b00; a_addr[0] = 32'h600; a_addr[1] = 32'h700;
    @(posedge clock); #1;
    chk1 ("seq tie owner", owner, 1'b0);
    chk1 ("seq tie mem_en", mem_en, 1'b1);
    chk32("seq tie mem_address", mem_address, 32'h600);
    repeat (MW) @(posedge clock);
    @(posedge clock); #1;
    chk1("seq tie cpu_ack", cpu_ack, 1'b1);
    chk1("seq tie dma_ack", dma_ack, 1'b0);
    chk1("seq tie done mem_en", mem_en, 1'b0);
    a_req = 2'b00;

    // ---------------- randomized run against the model ----------------
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    use_hash = 1'b1;
    m_act = 0; m_acc_s = 0; m_ack_t = 0;
    m_win = 1'b0; m_last = 1'b1; m_own = 1'b0; m_rw = 1'b0;
    m_addr = '0; m_dat = '0; m_rd = '0;
    for (int t = 0; t < 3000; t++) begin
      logic e_en, e_busy, e_ack;
      @(posedge clock); #1;
      if (m_act && t == m_acc_s) m_own = m_win;
      if (m_act && t == m_ack_t && !m_rw) m_rd = hash(m_addr);
      e_en   = m_act && t >= m_acc_s && t <= m_acc_s + MW;
      e_busy = m_act && t >= m_acc_s && t <= m_ack_t;
      e_ack  = m_act && t == m_ack_t;
      chk1 ($sformatf("rnd%0d mem_en", t),   mem_en,   e_en);
      chk1 ($sformatf("rnd%0d busy", t),     busy,     e_busy);
      chk1 ($sformatf("rnd%0d cpu_ack", t),  cpu_ack,  e_ack && !m_win);
      chk1 ($sformatf("rnd%0d dma_ack", t),  dma_ack,  e_ack && m_win);
      chk1 ($sformatf("rnd%0d owner", t),    owner,    m_own);
      chk32($sformatf("rnd%0d cpu_data", t), cpu_data, m_rd);
      chk32($sformatf("rnd%0d dma_data", t), dma_data, m_rd);
      if (e_en) begin
        chk32($sformatf("rnd%0d mem_address", t), mem_address, m_addr);
        chk1 ($sformatf("rnd%0d mem_rw", t),      mem_rw,      m_rw);
        if (m_rw) chk32($sformatf("rnd%0d mem_datao", t), mem_datao, m_dat);
      end
      // Requesters: drop on ack, raise new requests, and let a waiting one
      // change its payload (only the value at grant time matters)
      for (int a = 0; a < 2; a++) begin
        if (e_ack && m_win == a[0]) begin
          a_req[a] = 1'b0;
        end else if (!a_req[a]) begin
          if ($urandom_range(0, 3) == 0) begin
            a_req[a] = 1'b1; a_rw[a] = 1'($urandom_range(0, 1));
            a_addr[a] = $urandom; a_dat[a] = $urandom;
          end
        end else if (!(m_act && m_win == a[0] && t <= m_ack_t) && $urandom_range(0, 7) == 0) begin
          a_rw[a] = 1'($urandom_range(0, 1)); a_addr[a] = $urandom; a_dat[a] = $urandom;
        end
      end
      // Grant decision when the port is free and someone is asking
      if ((!m_act || t > m_ack_t) && a_req != 2'b00) begin
        if (a_req == 2'b11) m_win = PRIO ? 1'b0 : ~m_last;
        else                m_win = a_req[1];
        m_last  = m_win;
        m_rw    = a_rw[m_win];
        m_addr  = a_addr[m_win];
        m_dat   = a_dat[m_win];
        m_acc_s = t + 1;
        m_ack_t = t + MW + 2;
        m_act   = 1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
